// File: rtl/usb_stream_scheduler.sv
// Packet scheduler in front of the FX2 slave-FIFO write port: arbitrates status vs video,
// inserts frame headers and closes short packets with PKTEND on sof, timeout or disable.
module usb_stream_scheduler #(
  parameter int                DATA_W      = 16,
  parameter int                PKT_WORDS   = 256,
  parameter int                TIMEOUT_CYC = 4096,
  parameter logic [DATA_W-1:0] HDR_WORD    = 16'hA55A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_valid,
  input  logic              vid_sof,
  output logic              vid_ready,
  input  logic [DATA_W-1:0] sts_data,
  input  logic              sts_valid,
  input  logic              sts_last,
  output logic              sts_ready,
  input  logic              usb_full_n,
  output logic [DATA_W-1:0] usb_wdata,
  output logic              usb_slwr,
  output logic              usb_pktend,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int CNT_W  = $clog2(PKT_WORDS + 1);
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  PKT_LAST  = CNT_W'(PKT_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {ARB, STS, VID, HDR, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   word_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               hdr_done;
  logic               sof_pending;
  logic               word_at_last;

  // A sof word is held back until its frame header has gone out.
  assign sof_pending  = vid_valid & vid_sof & ~hdr_done;
  assign word_at_last = (word_cnt == PKT_LAST);
  assign sts_ready    = (state == STS) & usb_full_n & sts_valid;
  assign vid_ready    = (state == VID) & usb_full_n & vid_valid & ~sof_pending;
  assign busy         = (state != ARB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      hdr_done    <= 1'b0;
      frame_count <= '0;
      usb_wdata   <= '0;
      usb_slwr    <= 1'b0;
      usb_pktend  <= 1'b0;
    end else begin
      usb_slwr   <= 1'b0;
      usb_pktend <= 1'b0;
      case (state)
        ARB: begin
          word_cnt <= '0;
          idle_cnt <= '0;
          if (sts_valid)
            state <= STS;
          else if (enable & vid_valid)
            state <= VID;
        end

        STS: begin
          if (sts_ready) begin
            usb_slwr  <= 1'b1;
            usb_wdata <= sts_data;
            if (word_at_last) begin
              word_cnt <= '0;
              state    <= ARB;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
              if (sts_last)
                state <= END;
            end
          end
        end

        VID: begin
          if (vid_ready) begin
            usb_slwr  <= 1'b1;
            usb_wdata <= vid_data;
            idle_cnt  <= '0;
            if (vid_sof)
              hdr_done <= 1'b0;
            if (word_at_last) begin
              word_cnt <= '0;
              state    <= ARB;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
              if (!enable)
                state <= END;
            end
          end else if (!enable) begin
            state <= (word_cnt != '0) ? END : ARB;
          end else if (sof_pending) begin
            state <= (word_cnt != '0) ? END : HDR;
          end else if (word_cnt == '0) begin
            // Nothing committed to this packet yet, so give status a chance.
            if (!vid_valid)
              state <= ARB;
          end else if (!vid_valid && usb_full_n) begin
            if (idle_cnt == IDLE_LAST)
              state <= END;
            else
              idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        HDR: begin
          if (usb_full_n) begin
            usb_slwr    <= 1'b1;
            usb_wdata   <= HDR_WORD;
            hdr_done    <= 1'b1;
            frame_count <= frame_count + 16'd1;
            word_cnt    <= CNT_W'(1);
            state       <= VID;
          end
        end

        END: begin
          if (usb_full_n) begin
            usb_pktend <= 1'b1;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            state      <= ARB;
          end
        end

        default: state <= ARB;
      endcase
    end
  end

endmodule
